// File: rtl/ysyx_rf_wb_arbiter.sv
// Register-file write-port sequencer: zero-sweeps all registers after reset,
// then round-robin arbitrates EXU/LSU/CSR writebacks onto a registered write port.
module ysyx_rf_wb_arbiter #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          exu_valid,
    input  logic [AW-1:0] exu_rd,
    input  logic [DW-1:0] exu_data,
    output logic          exu_ready,
    input  logic          lsu_valid,
    input  logic [AW-1:0] lsu_rd,
    input  logic [DW-1:0] lsu_data,
    output logic          lsu_ready,
    input  logic          csr_valid,
    input  logic [AW-1:0] csr_rd,
    input  logic [DW-1:0] csr_data,
    output logic          csr_ready,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          init_done
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [1:0]    ptr_q;
    logic [1:0]    ptr_d;
    logic          wr_en_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic          init_done_q;

    logic [3:0]    vld;
    logic [1:0]    c0, c1, c2;
    logic [1:0]    gidx;
    logic          hs;
    logic [AW-1:0] g_rd;
    logic [DW-1:0] g_data;

    // Bit 3 is padding so a 2-bit candidate index always lands in range.
    assign vld = {1'b0, csr_valid, lsu_valid, exu_valid};

    always_comb begin
        c0 = 2'd0;
        c1 = 2'd1;
        c2 = 2'd2;
        unique case (ptr_q)
            2'd1: begin
                c0 = 2'd1;
                c1 = 2'd2;
                c2 = 2'd0;
            end
            2'd2: begin
                c0 = 2'd2;
                c1 = 2'd0;
                c2 = 2'd1;
            end
            default: begin
                c0 = 2'd0;
                c1 = 2'd1;
                c2 = 2'd2;
            end
        endcase

        gidx = c0;
        if (vld[c0]) begin
            gidx = c0;
        end else if (vld[c1]) begin
            gidx = c1;
        end else if (vld[c2]) begin
            gidx = c2;
        end

        hs = (state_q == S_RUN) && (|vld);
        ptr_d = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;

        unique case (gidx)
            2'd1: begin
                g_rd   = lsu_rd;
                g_data = lsu_data;
            end
            2'd2: begin
                g_rd   = csr_rd;
                g_data = csr_data;
            end
            default: begin
                g_rd   = exu_rd;
                g_data = exu_data;
            end
        endcase
    end

    assign exu_ready = hs && (gidx == 2'd0);
    assign lsu_ready = hs && (gidx == 2'd1);
    assign csr_ready = hs && (gidx == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    wr_en_q <= 1'b1;
                    waddr_q <= cnt_q;
                    wdata_q <= '0;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == AW'(NREG - 1)) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    if (hs) begin
                        // x0 requests complete the handshake but never write.
                        wr_en_q <= (g_rd != '0);
                        waddr_q <= g_rd;
                        wdata_q <= g_data;
                        ptr_q   <= ptr_d;
                    end else begin
                        wr_en_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rf_wr_en  = wr_en_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ysyx_rf_wb_arbiter.sv
// Self-checking bench for ysyx_rf_wb_arbiter: directed vector table, reset/sweep
// sequences and randomized requesters checked against a queue-style reference model.
module tb_ysyx_rf_wb_arbiter;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          exu_valid = 1'b0, lsu_valid = 1'b0, csr_valid = 1'b0;
    logic [AW-1:0] exu_rd = '0, lsu_rd = '0, csr_rd = '0;
    logic [DW-1:0] exu_data = '0, lsu_data = '0, csr_data = '0;
    logic          exu_ready, lsu_ready, csr_ready;
    logic          rf_wr_en;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          init_done;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    ysyx_rf_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .csr_valid(csr_valid), .csr_rd(csr_rd), .csr_data(csr_data), .csr_ready(csr_ready),
        .rf_wr_en(rf_wr_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [2:0] rdy_vec();
        return {csr_ready, lsu_ready, exu_ready};
    endfunction

    // Releases reset at a negedge and checks the full zero sweep; readys must stay low.
    task automatic sweep_check(input string tag);
        rst_n = 1'b1;
        for (int i = 0; i < int'(NREG); i++) begin
            #1;
            chk({tag, " sweep ready"}, 32'(rdy_vec()), 32'd0);
            @(negedge clk);
            chk({tag, " sweep wr_en"}, 32'(rf_wr_en), 32'd1);
            chk({tag, " sweep waddr"}, 32'(rf_waddr), 32'(i));
            chk({tag, " sweep wdata"}, rf_wdata, 32'd0);
            chk({tag, " sweep init_done"}, 32'(init_done), (i == int'(NREG) - 1) ? 32'd1 : 32'd0);
        end
    endtask

    typedef struct {
        logic [2:0]    v;      // {csr, lsu, exu}
        logic [AW-1:0] erd, lrd, crd;
        logic [DW-1:0] ed, ld, cd;
        logic [2:0]    rdy;    // expected {csr, lsu, exu} ready
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [AW-1:0] erd, input logic [DW-1:0] ed,
                                input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                                input logic [AW-1:0] crd, input logic [DW-1:0] cd,
                                input logic [2:0] rdy, input logic wen,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        vec_t r;
        r.v = v; r.erd = erd; r.ed = ed; r.lrd = lrd; r.ld = ld; r.crd = crd; r.cd = cd;
        r.rdy = rdy; r.wen = wen; r.waddr = wa; r.wdata = wd;
        return r;
    endfunction

    // Reference model state for the random phase.
    bit            pv[3];
    logic [AW-1:0] prd[3];
    logic [DW-1:0] pd[3];
    int            mptr;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;

    task automatic drive_pending();
        exu_valid = pv[0]; exu_rd = prd[0]; exu_data = pd[0];
        lsu_valid = pv[1]; lsu_rd = prd[1]; lsu_data = pd[1];
        csr_valid = pv[2]; csr_rd = prd[2]; csr_data = pd[2];
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset wr_en", 32'(rf_wr_en), 32'd0);
        chk("reset waddr", 32'(rf_waddr), 32'd0);
        chk("reset wdata", rf_wdata, 32'd0);
        chk("reset init_done", 32'(init_done), 32'd0);
        chk("reset ready", 32'(rdy_vec()), 32'd0);

        sweep_check("init");

        // Directed table; ptr = EXU on entry. Outputs are those after the row's edge.
        vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 5'd31, 32'h0));
        vt.push_back(mk(3'b001, 5, 32'hDEADBEEF, 0, 0, 0, 0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF));
        vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF));
        vt.push_back(mk(3'b100, 0, 0, 0, 0, 4, 32'h44, 3'b100, 1'b1, 5'd4, 32'h44));
        for (int k = 0; k < 4; k++) begin
            logic [2:0]    rr;
            logic [AW-1:0] aa;
            logic [DW-1:0] dd;
            rr = (k % 3 == 0) ? 3'b001 : (k % 3 == 1) ? 3'b010 : 3'b100;
            aa = AW'(k % 3 + 1);
            dd = 32'(k % 3 + 1) * 32'h11;
            vt.push_back(mk(3'b111, 1, 32'h11, 2, 32'h22, 3, 32'h33, rr, 1'b1, aa, dd));
        end
        vt.push_back(mk(3'b010, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 3'b010, 1'b0, 5'd0, 32'hFFFFFFFF));
        vt.push_back(mk(3'b100, 0, 0, 0, 0, 7, 32'h77, 3'b100, 1'b1, 5'd7, 32'h77));
        vt.push_back(mk(3'b001, 8, 32'h88, 0, 0, 0, 0, 3'b001, 1'b1, 5'd8, 32'h88));
        vt.push_back(mk(3'b101, 9, 32'h99, 0, 0, 10, 32'hAA, 3'b100, 1'b1, 5'd10, 32'hAA));
        vt.push_back(mk(3'b001, 9, 32'h99, 0, 0, 0, 0, 3'b001, 1'b1, 5'd9, 32'h99));
        vt.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 5'd9, 32'h99));

        foreach (vt[i]) begin
            exu_valid = vt[i].v[0]; exu_rd = vt[i].erd; exu_data = vt[i].ed;
            lsu_valid = vt[i].v[1]; lsu_rd = vt[i].lrd; lsu_data = vt[i].ld;
            csr_valid = vt[i].v[2]; csr_rd = vt[i].crd; csr_data = vt[i].cd;
            #1;
            chk($sformatf("vec%0d ready", i), 32'(rdy_vec()), 32'(vt[i].rdy));
            @(negedge clk);
            chk($sformatf("vec%0d wr_en", i), 32'(rf_wr_en), 32'(vt[i].wen));
            chk($sformatf("vec%0d waddr", i), 32'(rf_waddr), 32'(vt[i].waddr));
            chk($sformatf("vec%0d wdata", i), rf_wdata, vt[i].wdata);
        end

        // Random phase: requesters hold requests until accepted; ptr is LSU after the table.
        mptr = 1;
        e_waddr = 5'd9;
        e_wdata = 32'h99;
        for (int c = 0; c < 3; c++) pv[c] = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            int g;
            logic [2:0] erdy;
            for (int c = 0; c < 3; c++) begin
                if (!pv[c] && $urandom_range(0, 2) != 0) begin
                    pv[c]  = 1'b1;
                    prd[c] = AW'($urandom_range(0, 31));
                    pd[c]  = $urandom;
                end
            end
            drive_pending();
            g = -1;
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && pv[(mptr + k) % 3]) g = (mptr + k) % 3;
            end
            erdy = (g < 0) ? 3'b000 : 3'(1 << g);
            #1;
            chk("rand ready", 32'(rdy_vec()), 32'(erdy));
            if (g >= 0) begin
                e_wen   = (prd[g] != 0);
                e_waddr = prd[g];
                e_wdata = pd[g];
                pv[g]   = 1'b0;
                mptr    = (g + 1) % 3;
            end else begin
                e_wen = 1'b0;
            end
            @(negedge clk);
            chk("rand wr_en", 32'(rf_wr_en), 32'(e_wen));
            chk("rand waddr", 32'(rf_waddr), 32'(e_waddr));
            chk("rand wdata", rf_wdata, e_wdata);
        end

        // Mid-run reset while a write sits on the port
        lsu_valid = 1'b0; csr_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h1234;
        #1;
        chk("midrst pre ready", 32'(rdy_vec()), 32'b001);
        @(negedge clk);
        chk("midrst write on port", 32'(rf_wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst async wr_en", 32'(rf_wr_en), 32'd0);
        chk("midrst async ready", 32'(rdy_vec()), 32'd0);
        chk("midrst async init_done", 32'(init_done), 32'd0);
        chk("midrst async waddr", 32'(rf_waddr), 32'd0);
        @(negedge clk);
        sweep_check("rerun");
        #1;
        chk("first RUN ready", 32'(rdy_vec()), 32'b001);
        @(negedge clk);
        chk("first RUN wr_en", 32'(rf_wr_en), 32'd1);
        chk("first RUN waddr", 32'(rf_waddr), 32'd3);
        chk("first RUN wdata", rf_wdata, 32'h1234);
        exu_valid = 1'b0;
        @(negedge clk);
        chk("idle wr_en", 32'(rf_wr_en), 32'd0);
        chk("idle init_done", 32'(init_done), 32'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/ysyx_rf_wb_arbiter.md
Name: ysyx_rf_wb_arbiter

Overview:
- Sequences and shares the single write port of the 32x32 integer register file.
- After reset, sweeps every register to zero, one write per cycle.
- Then arbitrates round-robin between three writeback requesters: EXU (ALU result), LSU (load data) and CSR unit. Each uses a valid/ready handshake.
- Drives the register-file write port (rf_wr_en/waddr/wdata) from registered outputs, between the execute/memory stages and the register file.

Parameters:
NREG, 32, number of architectural registers swept at init (power of two).
AW, 5, register address width, log2(NREG).
DW, 32, data width.

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
exu_valid  in  1  EXU writeback request
exu_rd  in  AW  EXU destination register
exu_data  in  DW  EXU write data
exu_ready  out  1  EXU request accepted this cycle
lsu_valid  in  1  LSU writeback request
lsu_rd  in  AW  LSU destination register
lsu_data  in  DW  LSU write data
lsu_ready  out  1  LSU request accepted this cycle
csr_valid  in  1  CSR writeback request
csr_rd  in  AW  CSR destination register
csr_data  in  DW  CSR write data
csr_ready  out  1  CSR request accepted this cycle
rf_wr_en  out  1  register-file write enable (registered)
rf_waddr  out  AW  register-file write address (registered)
rf_wdata  out  DW  register-file write data (registered)
init_done  out  1  high once the zero sweep has completed (registered)

Behaviour:
- Reset (async, rst_n=0):
  - State = INIT; sweep counter cnt = 0; round-robin pointer ptr = 0 (EXU).
  - rf_wr_en = 0, rf_waddr = 0, rf_wdata = 0, init_done = 0.
  - All *_ready = 0 (combinational, gated by state).
- Reset asserted mid-operation: everything returns to the values above immediately.
  - A write already presented on the outputs is abandoned.
  - The sweep restarts from register 0 after release.
- States: INIT, RUN. There is no other state, and RUN is left only through reset.
- INIT:
  - On each posedge: rf_wr_en <= 1, rf_waddr <= cnt, rf_wdata <= 0, cnt <= cnt+1.
  - On the edge where cnt == NREG-1: state <= RUN, init_done <= 1.
  - Exactly NREG writes, addresses 0..NREG-1 in order, on the first NREG edges after rst_n rises.
  - All *_ready = 0 throughout INIT; requester valids are ignored, not lost. Requesters hold them.
- RUN arbitration (combinational):
  - Candidate order is ptr, ptr+1, ptr+2 (mod 3), with 0=EXU, 1=LSU, 2=CSR.
  - Grant goes to the first candidate with valid=1. Only the granted requester sees ready=1.
  - ready never asserts without the matching valid.
  - Handshake = valid & ready in the same cycle; at most one handshake per cycle.
- RUN outputs, on each posedge:
  - If a handshake occurred: rf_waddr <= granted rd, rf_wdata <= granted data, rf_wr_en <= (rd != 0), ptr <= (granted+1) mod 3.
  - If no handshake: rf_wr_en <= 0; rf_waddr/rf_wdata hold; ptr holds.
- Latency: the write appears on the port one cycle after the handshake cycle. The register-file commit occurs on the following edge.
- x0: a request with rd = 0 still completes its handshake and advances ptr, but produces no write (rf_wr_en = 0).
- Requester rules: valid, rd and data are held stable until the handshake; valid may not drop before ready. The arbiter never drops a granted request.
- Throughput: one write per cycle sustained. With all three valid continuously, grants rotate EXU, LSU, CSR, EXU, ...
- First RUN cycle: readys may assert in the cycle immediately after the edge that set init_done. The write from that handshake follows the last sweep write back-to-back.

Test Plan:
- Reset release with no requests: 32 consecutive cycles of rf_wr_en=1, waddr 0..31, wdata=0. Then rf_wr_en=0, init_done=1, and all readys stay 0 during the sweep even with exu_valid=1 held.
- After init, EXU only: exu_rd=5, exu_data=0xDEADBEEF → exu_ready=1 in that cycle. Next cycle: rf_wr_en=1, waddr=5, wdata=0xDEADBEEF. The cycle after: rf_wr_en=0.
- All three valid continuously (rd=1/2/3, data=0x11/0x22/0x33) → grants EXU, LSU, CSR, EXU. Writes waddr 1, 2, 3, 1 on consecutive cycles, with only one ready high per cycle.
- LSU request with lsu_rd=0, data=0xFFFFFFFF → lsu_ready=1 and ptr advances, but rf_wr_en stays 0. A following CSR-only request with rd=7 is granted next cycle.
- Pointer fairness: EXU granted once, then EXU and CSR both valid → LSU idle is skipped, so the next grant is CSR, not EXU.
- rst_n pulsed low mid-RUN while a write is on the port → rf_wr_en, readys and init_done go 0 asynchronously. After release, a full 32-write zero sweep repeats from address 0.
